// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared constants, state encoding and width helper for the ring-oscillator measurement path
package ro_meas_pkg;
  localparam int COUNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;
  function automatic int acc_width(input int count_w, input int log2_n);
    return count_w + log2_n;
  endfunction
endpackage

// File: rtl/ro_minmax_tracker.sv
// ro_minmax_tracker: running min/max of strobed samples, cleared at the start of each run
module ro_minmax_tracker #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         sample_i,
  input  logic [W-1:0] value_i,
  output logic [W-1:0] min_next_o,
  output logic [W-1:0] max_next_o
);
  logic [W-1:0] min_q, min_d, max_q, max_d;
  // next min/max including the sample on this edge, so the owner can snapshot the final sample
  always_comb begin
    min_d = clr_i ? '1 : (sample_i && value_i < min_q) ? value_i : min_q;
    max_d = clr_i ? '0 : (sample_i && value_i > max_q) ? value_i : max_q;
  end
  // running extremes
  always_ff @(posedge clk) begin
    min_q <= rst ? '1 : min_d;
    max_q <= rst ? '0 : max_d;
  end
  assign min_next_o = min_d;
  assign max_next_o = max_d;
endmodule

// File: rtl/ro_count_averager.sv
// ro_count_averager: averages 2^LOG2_N ring counts and presents the result on valid/ready; RO_MINMAX_EN adds min/max outputs
module ro_count_averager
  import ro_meas_pkg::*;
#(
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int LOG2_N     = 3,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] value_in,
  input  logic               value_valid,
  output logic [COUNT_W-1:0] avg_out,
  output logic               avg_valid,
  input  logic               avg_ready,
  output logic               busy,
`ifdef RO_MINMAX_EN
  output logic [COUNT_W-1:0] min_out,
  output logic [COUNT_W-1:0] max_out,
`endif
  output logic               overrun
);
  localparam int ACC_W = acc_width(COUNT_W, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** LOG2_N) - 1);
  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] avg_q, avg_d;
  logic               ovr_q, ovr_d;
  logic               last_sample;
  assign sum         = acc_q + ACC_W'(value_in);
  assign last_sample = state_q == ACCUM && value_valid && cnt_q == LAST;
  // control FSM: accumulate, publish the truncated mean, wait for the handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovr_d   = 1'b0;
      end
      ACCUM: if (value_valid) begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          avg_d   = sum[ACC_W-1:LOG2_N];
        end
      end
      DONE: begin
        if (value_valid) ovr_d = 1'b1;
        if (avg_ready) begin
          state_d = CONTINUOUS ? ACCUM : IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      ovr_q   <= ovr_d;
    end
  end
  assign avg_out   = avg_q;
  assign avg_valid = state_q == DONE;
  assign busy      = state_q == ACCUM;
  assign overrun   = ovr_q;
`ifdef RO_MINMAX_EN
  logic               run_clr;
  logic [COUNT_W-1:0] min_nxt, max_nxt, min_q, max_q;
  assign run_clr = (state_q == IDLE && start) || (CONTINUOUS && state_q == DONE && avg_ready);
  ro_minmax_tracker #(.W(COUNT_W)) u_minmax (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (run_clr),
    .sample_i  (state_q == ACCUM && value_valid),
    .value_i   (value_in),
    .min_next_o(min_nxt),
    .max_next_o(max_nxt)
  );
  // snapshot extremes alongside the average
  always_ff @(posedge clk) begin
    min_q <= rst ? '1 : last_sample ? min_nxt : min_q;
    max_q <= rst ? '0 : last_sample ? max_nxt : max_q;
  end
  assign min_out = min_q;
  assign max_out = max_q;
`else
  logic unused_last;
  assign unused_last = last_sample;
`endif
endmodule

// File: doc/ro_count_averager.md
Name: ro_count_averager

Overview:
- Downstream consumer of the ring-oscillator counting stage. Takes each gated ring-edge count, accumulates 2^LOG2_N consecutive samples and produces their average.
- Presents the result on a valid/ready handshake to the reporting logic (UART/readout).
- Reduces measurement jitter before the frequency value leaves the measurement path.

Parameters:
- COUNT_W, 16, width of incoming count and of average output.
- LOG2_N, 3, log2 of samples per average (N = 8); legal range 0..8.
- CONTINUOUS, 0, 1 = start a new average automatically after each handshake; 0 = wait for start.

Ports:
- clk  input  1  system clock (same clock as the counting stage's gate counter).
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse; begins a new averaging run when idle.
- value_in  input  COUNT_W  measured ring count from the counting stage.
- value_valid  input  1  one-cycle strobe; value_in is a completed measurement.
- avg_out  output  COUNT_W  averaged count.
- avg_valid  output  1  avg_out holds a result not yet accepted.
- avg_ready  input  1  downstream accepts avg_out when high with avg_valid.
- busy  output  1  high while in ACCUM.
- overrun  output  1  sticky; a sample arrived while a result was pending.
- min_out / max_out  output  COUNT_W  only with RO_MINMAX_EN.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, accumulator=0, sample count=0, avg_out=0, avg_valid=0, busy=0, overrun=0, min_out=all ones, max_out=0. Reset takes priority over every other input and aborts any run in progress with no partial result.
- Accumulator width is COUNT_W+LOG2_N bits, so it cannot overflow. Average = accumulator >> LOG2_N, truncated (no rounding).
- IDLE:
  - start=1 → ACCUM next cycle. Accumulator, sample count and overrun are cleared on entry.
  - value_valid is ignored.
- ACCUM (busy=1):
  - Each value_valid adds value_in, including value_in = 0.
  - start is ignored.
  - On the N-th valid sample: avg_out <= (acc + value_in) >> LOG2_N and avg_valid <= 1 on the same edge. avg_valid is therefore visible the cycle after the last strobe (latency 1). State → DONE.
- DONE (avg_valid=1):
  - avg_out is held stable until avg_valid && avg_ready.
  - Any value_valid while in DONE is dropped and sets overrun=1.
  - On handshake, avg_valid <= 0 next cycle. State → ACCUM with cleared accumulator and count if CONTINUOUS=1, else → IDLE.
  - start is ignored in DONE.
- avg_ready high while avg_valid=0 has no effect.
- The handshake edge and a value_valid on the same cycle in DONE: the sample is dropped and overrun is set. Samples are never counted into the next run.
- If CONTINUOUS=1, start in IDLE is still honoured (first run).
- overrun is cleared only by rst or by a start accepted in IDLE.
- LOG2_N=0: each sample passes straight through with latency 1.

Optional Feature:
- Macro RO_MINMAX_EN.
- Defined:
  - Tracks minimum and maximum valid sample per run. Trackers reset to all ones / 0 on run entry.
  - min_out and max_out update together with avg_out and hold with it until the handshake.
- Undefined: the ports are absent and no tracking logic is built.

Decomposition:
- Package ro_meas_pkg holds:
  - COUNT_W default constant (16).
  - State enum (IDLE, ACCUM, DONE; 2-bit encoding).
  - Function computing accumulator width.
- One sub-module, ro_minmax_tracker (clear, sample strobe, value → running min/max), instantiated only under RO_MINMAX_EN.
- Accumulate/control FSM stays in the top.

Test Plan:
- Basic average: LOG2_N=2, start, samples 10, 20, 30, 41 → avg_out=25 (101>>2), avg_valid one cycle after the 4th strobe, busy drops; with RO_MINMAX_EN min_out=10, max_out=41.
- Full-scale: four samples of 0xFFFF → avg_out=0xFFFF, no wrap. Four samples of 0 → avg_out=0, avg_valid=1.
- Backpressure: after result, hold avg_ready=0 for 5 cycles and strobe 2 samples → avg_out stable, overrun=1. Raise avg_ready → avg_valid=0 next cycle, state IDLE. Next start clears overrun.
- Mid-run reset: rst after 2 of 4 samples → all outputs at reset values. A new start plus 4 samples of 8 → avg_out=8 with no contamination.
- Ignored start and continuous mode:
  - start pulses during ACCUM do not restart (samples 4, 4, 4, 4 → 4).
  - CONTINUOUS=1: after handshake the next 4 samples 100 each yield avg_out=100 without start.
- Pass-through: LOG2_N=0, sample 1234 → avg_out=1234, avg_valid one cycle later.
